id_ex_stage: RTL and testbench

Decode and operand-select stage that sits directly upstream of the RV32IM execute ALU, registering everything the ALU and branch logic consume. It turns a fetched instruction plus register-file read data into the ALU's `opr_1`/`opr_2`/`alu_op`/`flag`/`eq` controls and the side-band controls for later stages. It also handles EX/WB operand bypass, the load-use interlock, flush and the valid/ready pipeline handshake.

---
 rtl/riscv_pkg.sv | 62 ++++++
 rtl/imm_gen.sv | 27 ++
 rtl/id_ex_stage.sv | 203 ++++++++++++++++++++
 tb/tb_id_ex_stage.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32IM decode definitions: opcodes, ALU op codes, the control bundle
// and the operand bypass selector used by the decode/operand-select stage.
package riscv_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   typedef enum logic [3:0] {
      ALU_ADD    = 4'd0,
      ALU_SLL    = 4'd1,
      ALU_SLT    = 4'd2,
      ALU_SLTU   = 4'd3,
      ALU_XOR    = 4'd4,
      ALU_SRL    = 4'd5,
      ALU_OR     = 4'd6,
      ALU_AND    = 4'd7,
      ALU_MUL    = 4'd8,
      ALU_MULH   = 4'd9,
      ALU_MULHSU = 4'd10,
      ALU_MULHU  = 4'd11,
      ALU_DIV    = 4'd12,
      ALU_DIVU   = 4'd13,
      ALU_REM    = 4'd14,
      ALU_REMU   = 4'd15
   } alu_op_e;

   typedef struct packed {
      logic is_branch;
      logic is_jump;
      logic mem_read;
      logic mem_write;
      logic reg_write;
      logic illegal;
   } ctrl_t;

   // x0 first, then the instruction in EX, then writeback, then the register file.
   function automatic logic [31:0] bypass_sel(
      input logic [4:0]  rs,
      input logic [31:0] rf_data,
      input logic        ex_ok,
      input logic [4:0]  ex_rd,
      input logic [31:0] ex_data,
      input logic        wb_ok,
      input logic [4:0]  wb_rd,
      input logic [31:0] wb_data
   );
      logic [31:0] r;
      if (rs == 5'd0)                  r = 32'd0;
      else if (ex_ok && ex_rd == rs)   r = ex_data;
      else if (wb_ok && wb_rd == rs)   r = wb_data;
      else                             r = rf_data;
      return r;
   endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate extraction; the format (I/S/B/U/J) follows the opcode.
module imm_gen
   import riscv_pkg::*;
(
   input  logic [31:0] instr,
   output logic [31:0] imm
);

   always_comb begin
      imm = 32'd0;
      case (instr[6:0])
         OPC_OP_IMM, OPC_LOAD, OPC_JALR:
            imm = {{20{instr[31]}}, instr[31:20]};
         OPC_STORE:
            imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         OPC_BRANCH:
            imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         OPC_LUI, OPC_AUIPC:
            imm = {instr[31:12], 12'd0};
         OPC_JAL:
            imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default:
            imm = 32'd0;
      endcase
   end

endmodule

// File: rtl/id_ex_stage.sv
// Decode and operand-select stage feeding the RV32IM execute ALU, with EX/WB
// bypass, load-use interlock, flush and a registered valid/ready output slot.
module id_ex_stage
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_n,
   input  logic        valid_i,
   output logic        ready_o,
   input  logic [31:0] instr_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] rs1_data_i,
   input  logic [31:0] rs2_data_i,
   input  logic [31:0] ex_result_i,
   input  logic        wb_valid_i,
   input  logic [4:0]  wb_rd_i,
   input  logic [31:0] wb_data_i,
   input  logic        flush_i,
   input  logic        ready_i,
   output logic        valid_o,
   output logic [31:0] opr_1_o,
   output logic [31:0] opr_2_o,
   output logic [3:0]  alu_op_o,
   output logic        flag_o,
   output logic        eq_o,
   output logic        is_branch_o,
   output logic        is_jump_o,
   output logic        mem_read_o,
   output logic        mem_write_o,
   output logic        reg_write_o,
   output logic        illegal_o,
   output logic [4:0]  rd_o,
   output logic [31:0] store_data_o,
   output logic [31:0] target_o,
   output logic [31:0] pc_o
);

   logic [6:0]  opcode;
   logic [2:0]  f3;
   logic [4:0]  rs1, rs2, rd;
   logic [31:0] imm;
   logic [31:0] rs1_val, rs2_val;
   logic        ex_ok;
   logic        uses_rs1, uses_rs2;
   logic        hazard;
   ctrl_t       ctrl_q;

   logic [31:0] d_opr1, d_opr2, d_target, d_store;
   logic [3:0]  d_alu;
   logic        d_flag, d_eq;
   logic [4:0]  d_rd;
   ctrl_t       d_ctrl;

   assign opcode = instr_i[6:0];
   assign f3     = instr_i[14:12];
   assign rs1    = instr_i[19:15];
   assign rs2    = instr_i[24:20];
   assign rd     = instr_i[11:7];

   imm_gen u_imm_gen (
      .instr (instr_i),
      .imm   (imm)
   );

   // A load in EX has no result yet, so it is never a bypass source.
   assign ex_ok   = valid_o & ctrl_q.reg_write & ~ctrl_q.mem_read;
   assign rs1_val = bypass_sel(rs1, rs1_data_i, ex_ok, rd_o, ex_result_i, wb_valid_i, wb_rd_i, wb_data_i);
   assign rs2_val = bypass_sel(rs2, rs2_data_i, ex_ok, rd_o, ex_result_i, wb_valid_i, wb_rd_i, wb_data_i);

   assign uses_rs1 = (opcode == OPC_OP) | (opcode == OPC_OP_IMM) | (opcode == OPC_BRANCH) |
                     (opcode == OPC_LOAD) | (opcode == OPC_STORE) | (opcode == OPC_JALR);
   assign uses_rs2 = (opcode == OPC_OP) | (opcode == OPC_BRANCH) | (opcode == OPC_STORE);

   assign hazard = valid_o & ctrl_q.mem_read & (rd_o != 5'd0) &
                   ((uses_rs1 & (rs1 == rd_o)) | (uses_rs2 & (rs2 == rd_o)));

   // Handshake: an instruction moves in when valid_i & ready_o; the output slot
   // holds its contents while valid_o & ~ready_i, and empties when ready_i is
   // high with nothing accepted. Flush empties the slot and refuses the input.
   assign ready_o = (~valid_o | ready_i) & ~hazard & ~flush_i;

   always_comb begin
      d_opr1   = 32'd0;
      d_opr2   = 32'd0;
      d_alu    = ALU_ADD;
      d_flag   = 1'b0;
      d_eq     = 1'b0;
      d_ctrl   = '0;
      d_target = 32'd0;
      d_store  = 32'd0;
      d_rd     = 5'd0;
      case (opcode)
         OPC_OP: begin
            d_opr1 = rs1_val;
            d_opr2 = rs2_val;
            d_alu  = {instr_i[25], f3};
            d_flag = instr_i[30] & ~instr_i[25] & ((f3 == 3'b000) | (f3 == 3'b101));
            d_ctrl.reg_write = 1'b1;
         end
         OPC_OP_IMM: begin
            d_opr1 = rs1_val;
            d_opr2 = imm;
            d_alu  = {1'b0, f3};
            d_flag = instr_i[30] & (f3 == 3'b101);
            d_ctrl.reg_write = 1'b1;
         end
         OPC_BRANCH: begin
            d_opr1   = rs1_val;
            d_opr2   = rs2_val;
            d_alu    = {2'b00, instr_i[14:13]};
            d_flag   = ~instr_i[14];
            d_eq     = ~(instr_i[14] ^ instr_i[12]);
            d_target = pc_i + imm;
            d_ctrl.is_branch = 1'b1;
         end
         OPC_LOAD: begin
            d_opr1 = rs1_val;
            d_opr2 = imm;
            d_ctrl.mem_read  = 1'b1;
            d_ctrl.reg_write = 1'b1;
         end
         OPC_STORE: begin
            d_opr1  = rs1_val;
            d_opr2  = imm;
            d_store = rs2_val;
            d_ctrl.mem_write = 1'b1;
         end
         OPC_LUI: begin
            d_opr2 = imm;
            d_ctrl.reg_write = 1'b1;
         end
         OPC_AUIPC: begin
            d_opr1 = pc_i;
            d_opr2 = imm;
            d_ctrl.reg_write = 1'b1;
         end
         OPC_JAL: begin
            d_opr1   = pc_i;
            d_opr2   = 32'd4;
            d_target = pc_i + imm;
            d_ctrl.is_jump   = 1'b1;
            d_ctrl.reg_write = 1'b1;
         end
         OPC_JALR: begin
            d_opr1   = pc_i;
            d_opr2   = 32'd4;
            d_target = (rs1_val + imm) & ~32'd1;
            d_ctrl.is_jump   = 1'b1;
            d_ctrl.reg_write = 1'b1;
         end
         default: d_ctrl.illegal = 1'b1;
      endcase
      if (rd == 5'd0)
         d_ctrl.reg_write = 1'b0;
      if (d_ctrl.reg_write)
         d_rd = rd;
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         valid_o      <= 1'b0;
         ctrl_q       <= '0;
         opr_1_o      <= 32'd0;
         opr_2_o      <= 32'd0;
         alu_op_o     <= 4'd0;
         flag_o       <= 1'b0;
         eq_o         <= 1'b0;
         rd_o         <= 5'd0;
         store_data_o <= 32'd0;
         target_o     <= 32'd0;
         pc_o         <= RESET_PC;
      end else if (flush_i) begin
         valid_o <= 1'b0;
         ctrl_q  <= '0;
      end else if (valid_i && ready_o) begin
         valid_o      <= 1'b1;
         ctrl_q       <= d_ctrl;
         opr_1_o      <= d_opr1;
         opr_2_o      <= d_opr2;
         alu_op_o     <= d_alu;
         flag_o       <= d_flag;
         eq_o         <= d_eq;
         rd_o         <= d_rd;
         store_data_o <= d_store;
         target_o     <= d_target;
         pc_o         <= pc_i;
      end else if (ready_i) begin
         // Slot drained with nothing new: this is also the load-use bubble.
         valid_o <= 1'b0;
         ctrl_q  <= '0;
      end
   end

   assign is_branch_o = ctrl_q.is_branch;
   assign is_jump_o   = ctrl_q.is_jump;
   assign mem_read_o  = ctrl_q.mem_read;
   assign mem_write_o = ctrl_q.mem_write;
   assign reg_write_o = ctrl_q.reg_write;
   assign illegal_o   = ctrl_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a decode vector table plus hand sequences for
// load-use, stall/flush and asynchronous reset.
module tb_id_ex_stage;

   logic        clk_i = 1'b0;
   logic        rst_n;
   logic        valid_i, ready_o;
   logic [31:0] instr_i, pc_i, rs1_data_i, rs2_data_i, ex_result_i;
   logic        wb_valid_i;
   logic [4:0]  wb_rd_i;
   logic [31:0] wb_data_i;
   logic        flush_i, ready_i, valid_o;
   logic [31:0] opr_1_o, opr_2_o;
   logic [3:0]  alu_op_o;
   logic        flag_o, eq_o;
   logic        is_branch_o, is_jump_o, mem_read_o, mem_write_o, reg_write_o, illegal_o;
   logic [4:0]  rd_o;
   logic [31:0] store_data_o, target_o, pc_o;

   id_ex_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk_i(clk_i), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
      .instr_i(instr_i), .pc_i(pc_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
      .ex_result_i(ex_result_i), .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i),
      .wb_data_i(wb_data_i), .flush_i(flush_i), .ready_i(ready_i), .valid_o(valid_o),
      .opr_1_o(opr_1_o), .opr_2_o(opr_2_o), .alu_op_o(alu_op_o), .flag_o(flag_o),
      .eq_o(eq_o), .is_branch_o(is_branch_o), .is_jump_o(is_jump_o),
      .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .reg_write_o(reg_write_o),
      .illegal_o(illegal_o), .rd_o(rd_o), .store_data_o(store_data_o),
      .target_o(target_o), .pc_o(pc_o)
   );

   always #5 clk_i = ~clk_i;

   localparam logic [5:0] C_BR = 6'b100000;
   localparam logic [5:0] C_JP = 6'b010000;
   localparam logic [5:0] C_MR = 6'b001000;
   localparam logic [5:0] C_MW = 6'b000100;
   localparam logic [5:0] C_RW = 6'b000010;
   localparam logic [5:0] C_IL = 6'b000001;
   localparam logic [31:0] A = 32'h1111_1111;
   localparam logic [31:0] B = 32'h2222_2222;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] opr1;
      logic [31:0] opr2;
      logic [3:0]  alu;
      logic        flag;
      logic        eq;
      logic [5:0]  ctrl;
      logic [4:0]  rd;
      logic [31:0] target;
      logic [31:0] store;
   } vec_t;

   localparam int NV = 16;
   vec_t vecs [NV];
   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [5:0] ctrl_now();
      return {is_branch_o, is_jump_o, mem_read_o, mem_write_o, reg_write_o, illegal_o};
   endfunction

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic [31:0] ins, input logic [31:0] pc);
      valid_i = 1'b1;
      instr_i = ins;
      pc_i    = pc;
   endtask

   initial begin
      rst_n = 1'b0;
      valid_i = 1'b0; instr_i = '0; pc_i = '0;
      rs1_data_i = A; rs2_data_i = B; ex_result_i = '0;
      wb_valid_i = 1'b0; wb_rd_i = '0; wb_data_i = '0;
      flush_i = 1'b0; ready_i = 1'b1;

      //                instr          pc            opr1          opr2          alu    f     eq    ctrl         rd     target        store
      vecs[0]  = '{32'hFFF00093, 32'h0,      32'h0,        32'hFFFFFFFF, 4'b0000, 1'b0, 1'b0, C_RW,        5'd1,  32'h0,        32'h0};
      vecs[1]  = '{32'h02000113, 32'h0,      32'h0,        32'h20,       4'b0000, 1'b0, 1'b0, C_RW,        5'd2,  32'h0,        32'h0};
      vecs[2]  = '{32'h402081B3, 32'h0,      A,            B,            4'b0000, 1'b1, 1'b0, C_RW,        5'd3,  32'h0,        32'h0};
      vecs[3]  = '{32'h022081B3, 32'h0,      A,            B,            4'b1000, 1'b0, 1'b0, C_RW,        5'd3,  32'h0,        32'h0};
      vecs[4]  = '{32'h4030D213, 32'h0,      A,            32'h403,      4'b0101, 1'b1, 1'b0, C_RW,        5'd4,  32'h0,        32'h0};
      vecs[5]  = '{32'h00209463, 32'h100,    A,            B,            4'b0000, 1'b1, 1'b0, C_BR,        5'd0,  32'h108,      32'h0};
      vecs[6]  = '{32'h0020F463, 32'h100,    A,            B,            4'b0011, 1'b0, 1'b1, C_BR,        5'd0,  32'h108,      32'h0};
      vecs[7]  = '{32'h0000A283, 32'h0,      A,            32'h0,        4'b0000, 1'b0, 1'b0, C_MR | C_RW, 5'd5,  32'h0,        32'h0};
      vecs[8]  = '{32'h0020A623, 32'h0,      A,            32'hC,        4'b0000, 1'b0, 1'b0, C_MW,        5'd0,  32'h0,        B};
      vecs[9]  = '{32'h12345437, 32'h0,      32'h0,        32'h12345000, 4'b0000, 1'b0, 1'b0, C_RW,        5'd8,  32'h0,        32'h0};
      vecs[10] = '{32'h00001497, 32'h200,    32'h200,      32'h1000,     4'b0000, 1'b0, 1'b0, C_RW,        5'd9,  32'h0,        32'h0};
      vecs[11] = '{32'h010000EF, 32'h300,    32'h300,      32'h4,        4'b0000, 1'b0, 1'b0, C_JP | C_RW, 5'd1,  32'h310,      32'h0};
      vecs[12] = '{32'h00808067, 32'h400,    32'h400,      32'h4,        4'b0000, 1'b0, 1'b0, C_JP,        5'd0,  32'h11111118, 32'h0};
      vecs[13] = '{32'h0000007F, 32'h0,      32'h0,        32'h0,        4'b0000, 1'b0, 1'b0, C_IL,        5'd0,  32'h0,        32'h0};
      vecs[14] = '{32'h00200533, 32'h0,      32'h0,        B,            4'b0000, 1'b0, 1'b0, C_RW,        5'd10, 32'h0,        32'h0};
      vecs[15] = '{32'h0020D1B3, 32'h0,      A,            B,            4'b0101, 1'b0, 1'b0, C_RW,        5'd3,  32'h0,        32'h0};

      // Reset state
      #1;
      chk("rst valid", valid_o, 1'b0);
      chk("rst pc", pc_o, 32'h0);
      chk("rst ctrl", ctrl_now(), 6'b0);
      chk("rst rd", rd_o, 5'd0);
      chk("rst opr1", opr_1_o, 32'h0);
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rst_n = 1'b1;
      step();
      chk("post-rst ready", ready_o, 1'b1);

      // Decode table: each vector followed by an idle cycle so no EX bypass applies
      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].instr, vecs[i].pc);
         step();
         chk($sformatf("v%0d valid", i), valid_o, 1'b1);
         chk($sformatf("v%0d opr1", i), opr_1_o, vecs[i].opr1);
         chk($sformatf("v%0d opr2", i), opr_2_o, vecs[i].opr2);
         chk($sformatf("v%0d alu_op", i), alu_op_o, vecs[i].alu);
         chk($sformatf("v%0d flag", i), flag_o, vecs[i].flag);
         chk($sformatf("v%0d eq", i), eq_o, vecs[i].eq);
         chk($sformatf("v%0d ctrl", i), ctrl_now(), vecs[i].ctrl);
         chk($sformatf("v%0d rd", i), rd_o, vecs[i].rd);
         chk($sformatf("v%0d target", i), target_o, vecs[i].target);
         chk($sformatf("v%0d store", i), store_data_o, vecs[i].store);
         chk($sformatf("v%0d pc", i), pc_o, vecs[i].pc);
         valid_i = 1'b0;
         step();
         chk($sformatf("v%0d idle valid", i), valid_o, 1'b0);
         chk($sformatf("v%0d idle ctrl", i), ctrl_now(), 6'b0);
      end

      // Load-use: LW x5 then ADD x6,x5,x5
      drive(32'h0000A283, 32'h600);
      step();
      chk("lu lw valid", valid_o, 1'b1);
      chk("lu lw rd", rd_o, 5'd5);
      drive(32'h00528333, 32'h604);
      rs1_data_i = 32'hBAD0BAD0; rs2_data_i = 32'hBAD0BAD0;
      #1;
      chk("lu ready low", ready_o, 1'b0);
      step();
      chk("lu bubble valid", valid_o, 1'b0);
      chk("lu bubble ctrl", ctrl_now(), 6'b0);
      wb_valid_i = 1'b1; wb_rd_i = 5'd5; wb_data_i = 32'hCAFE0005;
      #1;
      chk("lu ready back", ready_o, 1'b1);
      step();
      chk("lu add valid", valid_o, 1'b1);
      chk("lu add opr1", opr_1_o, 32'hCAFE0005);
      chk("lu add opr2", opr_2_o, 32'hCAFE0005);
      chk("lu add rd", rd_o, 5'd6);
      // ADD x7,x6,x0: EX bypass wins over a WB hit on the same register
      drive(32'h000303B3, 32'h608);
      wb_rd_i = 5'd6; wb_data_i = 32'hDEAD0006; ex_result_i = 32'h55AA0006;
      rs2_data_i = 32'h12345678;
      #1;
      chk("ex ready", ready_o, 1'b1);
      step();
      chk("ex opr1", opr_1_o, 32'h55AA0006);
      chk("ex opr2", opr_2_o, 32'h0);
      chk("ex rd", rd_o, 5'd7);
      valid_i = 1'b0; wb_valid_i = 1'b0;
      rs1_data_i = A; rs2_data_i = B;
      step();

      // Stall for 3 cycles, then flush the held instruction
      ready_i = 1'b0;
      drive(32'hFFF00093, 32'h40);
      step();
      chk("st valid", valid_o, 1'b1);
      drive(32'h02000113, 32'h44);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("st%0d ready", k), ready_o, 1'b0);
         step();
         chk($sformatf("st%0d valid", k), valid_o, 1'b1);
         chk($sformatf("st%0d rd", k), rd_o, 5'd1);
         chk($sformatf("st%0d opr2", k), opr_2_o, 32'hFFFFFFFF);
         chk($sformatf("st%0d pc", k), pc_o, 32'h40);
      end
      flush_i = 1'b1;
      ready_i = 1'b1;
      #1;
      chk("fl ready", ready_o, 1'b0);
      step();
      chk("fl valid", valid_o, 1'b0);
      chk("fl ctrl", ctrl_now(), 6'b0);
      flush_i = 1'b0;
      valid_i = 1'b0;
      step();
      chk("fl lost", valid_o, 1'b0);

      // Asynchronous reset while stalled
      ready_i = 1'b0;
      drive(32'hFFF00093, 32'h500);
      step();
      chk("ar held pc", pc_o, 32'h500);
      valid_i = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar valid", valid_o, 1'b0);
      chk("ar pc", pc_o, 32'h0);
      chk("ar ctrl", ctrl_now(), 6'b0);
      chk("ar rd", rd_o, 5'd0);
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rst_n = 1'b1;
      ready_i = 1'b1;
      step();
      chk("ar ready", ready_o, 1'b1);
      chk("ar still empty", valid_o, 1'b0);
      drive(32'h12345437, 32'h700);
      step();
      chk("ar lui valid", valid_o, 1'b1);
      chk("ar lui opr2", opr_2_o, 32'h12345000);
      chk("ar lui rd", rd_o, 5'd8);
      chk("ar lui pc", pc_o, 32'h700);
      valid_i = 1'b0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
